panel_sequencer: RTL
====================

Name: panel_sequencer

Overview:
- Front-panel conditioning stage directly upstream of the bus controller.
- Synchronises and debounces the RUN, STEP-ENABLE, STEP and RESET panel switches.
- Sequences the 68000 reset/halt release and produces the RUN, STEPEN and STEP levels that the bus controller consumes for DTACK stepping and bootstrap-mode reset.
- Also drives the CPU RESET/HALT requests; board logic inverts these to the open-drain pins.

Parameters:
- DEBOUNCE_CYCLES, 50000: consecutive stable cycles required before a debounced switch level changes; minimum 1.
- RESET_HOLD_CYCLES, 1024: cycles CPU_RESET/CPU_HALT stay asserted after a start or reset request; minimum 1.

Ports:
- CPUCLK_IN  input  1  CPU clock; all state is on its rising edge.
- RESET_IN  input  1  Synchronous, active-high block reset.
- RUN_SW_IN  input  1  Raw RUN switch; asynchronous, bouncy; 1 = run.
- STEPEN_SW_IN  input  1  Raw step-mode switch; 1 = stepper mode.
- STEP_SW_IN  input  1  Raw step push-button; 1 = pressed.
- RESET_SW_IN  input  1  Raw reset push-button; 1 = pressed.
- RUN  output  1  Run level to the bus controller; 1 only in RUNNING.
- CPU_RESET  output  1  CPU reset request; active-high.
- CPU_HALT  output  1  CPU halt request; active-high.
- STEPEN  output  1  Debounced step-mode level.
- STEP  output  1  Debounced step level, gated by STEPEN.
- STEP_PULSE  output  1  One-cycle strobe on each rising edge of STEP.
- STATE  output  2  Current state: 0 STOPPED, 1 HOLD, 2 RUNNING, 3 unused.

Behaviour:
- Reset (RESET_IN high at an edge):
  - STATE = STOPPED; RUN = 0; CPU_RESET = 1; CPU_HALT = 1.
  - STEPEN, STEP and STEP_PULSE = 0.
  - All debounced levels = 0; synchroniser flops = 0; all counters = 0.
  - Reset applied mid-HOLD or mid-debounce discards all progress.
- Input conditioning (per switch):
  - A 2-flop synchroniser feeds a debouncer, one independent instance per switch.
  - Debouncer: the counter clears whenever the synchronised value equals the debounced level; otherwise it increments.
  - When the counter reaches DEBOUNCE_CYCLES-1 while still differing, the debounced level flips on that edge and the counter clears.
  - Latency: a clean input change set up before edge N appears on the debounced level after edge N+1+DEBOUNCE_CYCLES.
  - A glitch shorter than DEBOUNCE_CYCLES synchronised cycles produces no change.
  - Counter width is clog2(DEBOUNCE_CYCLES), minimum 1 bit; the counter never wraps.
- State machine (dR/dS/dE/dP are debounced RUN/RESET/STEPEN/STEP):
  - STOPPED: RUN 0, CPU_RESET 1, CPU_HALT 1. Go to HOLD when dR = 1. The hold counter is cleared on entry.
  - HOLD: RUN 0, CPU_RESET 1, CPU_HALT 1.
    - While dS = 1, the hold counter stays at 0.
    - Otherwise the counter increments each cycle.
    - When it reaches RESET_HOLD_CYCLES-1, go to RUNNING on the next edge.
  - RUNNING: RUN 1, CPU_RESET 0, CPU_HALT 0.
    - dS = 1 -> go to HOLD (counter cleared).
  - Priority, all states: dR = 0 -> STOPPED, overriding a simultaneous dS or hold expiry.
  - STATE = 3 is unreachable; if entered, go to STOPPED next cycle.
  - All outputs are registered and change on the edge of the state transition.
- Stepping:
  - STEPEN = dE.
  - STEP = dP & dE, registered; STEP is 0 whenever dE = 0.
  - STEP_PULSE = 1 for exactly one cycle when STEP goes 0 -> 1. There is no pulse on the 1 -> 0 transition.
  - A 0 -> 1 transition of dE while dP = 1 counts as a STEP rise and gives one pulse.
  - STEP and STEPEN are independent of state; the bus controller ignores them when RUN = 0.
- Hold counter:
  - Width is clog2(RESET_HOLD_CYCLES), minimum 1 bit.
  - It saturates and never wraps.

Test Plan:
All tests use DEBOUNCE_CYCLES = 4 and RESET_HOLD_CYCLES = 8.
1. Power-up: RESET_IN high 3 cycles, then low -> STATE = 0, RUN = 0, CPU_RESET = CPU_HALT = 1, STEP = STEPEN = STEP_PULSE = 0.
2. Start: raise RUN_SW_IN before edge N -> dR rises at edge N+5 and STATE = 1 on the following edge. After 8 HOLD cycles, STATE = 2, RUN = 1, CPU_RESET = CPU_HALT = 0.
3. Bounce rejection: toggle RUN_SW_IN high for 3 cycles, low for 1, repeat 5 times, then hold low -> dR never rises, STATE stays 0.
4. Reset button: in RUNNING, press RESET_SW_IN for 20 cycles -> STATE = 1 while held; RUNNING resumes exactly 8 cycles after dS falls. Then drop RUN_SW_IN and press RESET_SW_IN together -> STATE = 0.
5. Stepping: STEPEN_SW_IN = 1, then press STEP_SW_IN 3 times (each 10 cycles on, 10 off) -> exactly 3 one-cycle STEP_PULSEs. With STEPEN_SW_IN = 0, a press gives STEP = 0 and no pulse.
6. Reset mid-HOLD: assert RESET_IN after the 5th HOLD cycle -> STATE = 0 next edge. A new start takes the full 8 HOLD cycles.

Source files
------------

// File: rtl/panel_sequencer_if.sv
`default_nettype none
// ============================================================================
// panel_sequencer_if : raw front-panel switches in, conditioned levels out
// Revision 1.0
// ============================================================================
interface panel_sequencer_if;
    logic       RUN_SW_IN;
    logic       STEPEN_SW_IN;
    logic       STEP_SW_IN;
    logic       RESET_SW_IN;
    logic       RUN;
    logic       CPU_RESET;
    logic       CPU_HALT;
    logic       STEPEN;
    logic       STEP;
    logic       STEP_PULSE;
    logic [1:0] STATE;

    // Panel side: drives the switches, observes the sequencer outputs
    modport master (
        output RUN_SW_IN, STEPEN_SW_IN, STEP_SW_IN, RESET_SW_IN,
        input  RUN, CPU_RESET, CPU_HALT, STEPEN, STEP, STEP_PULSE, STATE
    );

    modport slave (
        input  RUN_SW_IN, STEPEN_SW_IN, STEP_SW_IN, RESET_SW_IN,
        output RUN, CPU_RESET, CPU_HALT, STEPEN, STEP, STEP_PULSE, STATE
    );
endinterface
`default_nettype wire

// File: rtl/panel_sequencer.sv
`default_nettype none
// ============================================================================
// panel_sequencer : synchronise/debounce panel switches, sequence CPU reset/halt
// Revision 1.0
// ============================================================================
module panel_sequencer #(
    parameter int DEBOUNCE_CYCLES   = 50000,
    parameter int RESET_HOLD_CYCLES = 1024
) (
    input wire               CPUCLK_IN,
    input wire               RESET_IN,
    panel_sequencer_if.slave bus
);
    localparam int c_db_w   = (DEBOUNCE_CYCLES   > 1) ? $clog2(DEBOUNCE_CYCLES)   : 1;
    localparam int c_hold_w = (RESET_HOLD_CYCLES > 1) ? $clog2(RESET_HOLD_CYCLES) : 1;
    localparam logic [c_db_w-1:0]   c_db_last   = c_db_w'(DEBOUNCE_CYCLES - 1);
    localparam logic [c_db_w-1:0]   c_db_one    = c_db_w'(1);
    localparam logic [c_hold_w-1:0] c_hold_last = c_hold_w'(RESET_HOLD_CYCLES - 1);
    localparam logic [c_hold_w-1:0] c_hold_one  = c_hold_w'(1);

    typedef enum logic [1:0] {
        ST_STOPPED = 2'd0,
        ST_HOLD    = 2'd1,
        ST_RUNNING = 2'd2,
        ST_UNUSED  = 2'd3
    } state_t;

    // Switch index: 0 RUN, 1 STEPEN, 2 STEP, 3 RESET
    logic [3:0] w_raw;
    logic [3:0] w_deb;

    assign w_raw = {bus.RESET_SW_IN, bus.STEP_SW_IN, bus.STEPEN_SW_IN, bus.RUN_SW_IN};

    for (genvar g = 0; g < 4; g++) begin : g_debounce
        logic              r_sync1;
        logic              r_sync2;
        logic              r_level;
        logic [c_db_w-1:0] r_cnt;

        always_ff @(posedge CPUCLK_IN) begin
            if (RESET_IN) begin
                r_sync1 <= 1'b0;
                r_sync2 <= 1'b0;
                r_level <= 1'b0;
                r_cnt   <= '0;
            end else begin
                r_sync1 <= w_raw[g];
                r_sync2 <= r_sync1;
                if (r_sync2 == r_level) begin
                    r_cnt <= '0;
                end else if (r_cnt == c_db_last) begin
                    r_level <= r_sync2;
                    r_cnt   <= '0;
                end else begin
                    r_cnt <= r_cnt + c_db_one;
                end
            end
        end

        assign w_deb[g] = r_level;
    end

    logic w_run_sw;
    logic w_stepen_sw;
    logic w_step_sw;
    logic w_reset_sw;

    assign w_run_sw    = w_deb[0];
    assign w_stepen_sw = w_deb[1];
    assign w_step_sw   = w_deb[2];
    assign w_reset_sw  = w_deb[3];

    state_t              r_state;
    state_t              w_state_nxt;
    logic [c_hold_w-1:0] r_hold_cnt;
    logic [c_hold_w-1:0] w_hold_cnt_nxt;

    always_comb begin
        w_state_nxt    = r_state;
        w_hold_cnt_nxt = r_hold_cnt;
        case (r_state)
            ST_STOPPED: begin
                if (w_run_sw) begin
                    w_state_nxt    = ST_HOLD;
                    w_hold_cnt_nxt = '0;
                end
            end
            ST_HOLD: begin
                if (w_reset_sw) begin
                    w_hold_cnt_nxt = '0;
                end else if (r_hold_cnt == c_hold_last) begin
                    w_state_nxt = ST_RUNNING;
                end else begin
                    w_hold_cnt_nxt = r_hold_cnt + c_hold_one;
                end
            end
            ST_RUNNING: begin
                if (w_reset_sw) begin
                    w_state_nxt    = ST_HOLD;
                    w_hold_cnt_nxt = '0;
                end
            end
            default: begin
                w_state_nxt    = ST_STOPPED;
                w_hold_cnt_nxt = '0;
            end
        endcase
        // A dropped RUN switch wins over reset requests and hold expiry
        if (!w_run_sw) begin
            w_state_nxt    = ST_STOPPED;
            w_hold_cnt_nxt = '0;
        end
    end

    logic r_run;
    logic r_cpu_reset;
    logic r_cpu_halt;
    logic r_step;
    logic r_step_pulse;
    logic w_step_lvl;

    assign w_step_lvl = w_step_sw & w_stepen_sw;

    always_ff @(posedge CPUCLK_IN) begin
        if (RESET_IN) begin
            r_state      <= ST_STOPPED;
            r_hold_cnt   <= '0;
            r_run        <= 1'b0;
            r_cpu_reset  <= 1'b1;
            r_cpu_halt   <= 1'b1;
            r_step       <= 1'b0;
            r_step_pulse <= 1'b0;
        end else begin
            r_state      <= w_state_nxt;
            r_hold_cnt   <= w_hold_cnt_nxt;
            r_run        <= (w_state_nxt == ST_RUNNING);
            r_cpu_reset  <= (w_state_nxt != ST_RUNNING);
            r_cpu_halt   <= (w_state_nxt != ST_RUNNING);
            r_step       <= w_step_lvl;
            r_step_pulse <= w_step_lvl & ~r_step;
        end
    end

    assign bus.RUN        = r_run;
    assign bus.CPU_RESET  = r_cpu_reset;
    assign bus.CPU_HALT   = r_cpu_halt;
    assign bus.STEPEN     = w_stepen_sw;
    assign bus.STEP       = r_step;
    assign bus.STEP_PULSE = r_step_pulse;
    assign bus.STATE      = r_state;
endmodule
`default_nettype wire
